mem_byte_seq: RTL
=================

# mem_byte_seq

Byte-serial load/store sequencer sitting between the MEM pipeline stage and the memory controller's data-side port. It accepts one byte/half/word load or store request. It issues the required little-endian byte accesses one per cycle over the 8-bit controller interface, assembles and extends load data, and holds the pipeline stalled until the access completes. When idle it drives no request, so the controller grants the RAM to instruction fetch.

## Interface
Parameters:
- none (widths from shared defines: address 32, data 32, byte 8)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  MEM stage has an access this cycle; held stable while stall_req=1
- req_rw  in  2  01 load, 10 store; 00/11 = no access
- req_addr  in  32  byte address of lowest byte
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- req_wdata  in  32  store data, byte 0 in [7:0]
- rw_to_ctrl  out  2  01 load / 10 store / 00 idle toward controller
- addr_to_ctrl  out  32  byte address toward controller
- data_to_ctrl  out  8  store byte toward controller (0 when not storing)
- data_from_ctrl  in  8  read byte; valid the cycle after its address is driven
- stall_req  out  1  pipeline must hold
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid while done=1, 0 otherwise
- misalign  out  1  alignment fault, pulses with done (see Configuration)

## Operation
- States: IDLE, LOAD, STORE, DONE. Byte count N = 1/2/4 from req_size; counter k from 0.
- IDLE: rw_to_ctrl=00, addr/data 0. On req_valid with req_rw 01 or 10: latch addr/size/signed/wdata, k=0, go to LOAD or STORE. Other req_rw values are ignored.
- STORE: drive rw=10, addr=base+k, data=wdata byte k; k++; after byte N-1 go to DONE.
- LOAD: while k<N, drive rw=01, addr=base+k. In the cycle after byte j is driven, capture data_from_ctrl into result byte j. One extra cycle with rw=00 captures the last byte, then go to DONE.
- DONE: done=1, rdata = result sign/zero-extended from 8/16 bits (word unchanged; store gives 0). Then return to IDLE. req_valid is not sampled in DONE.
- Address arithmetic is 32-bit modulo: base+k wraps 0xFFFFFFFF→0x00000000.
- stall_req = (state is LOAD or STORE) or (state IDLE and req_valid and req_rw∈{01,10}); 0 in DONE.
- Reset in any state: next cycle state IDLE, all outputs 0, no done; any partial store is not rolled back.

## Timing
- Cycle 0 = request accepted in IDLE.
- Store: bytes driven cycles 1..N; done in cycle N+1 (SB 2, SH 3, SW 5).
- Load: bytes driven cycles 1..N, captured at end of cycles 2..N+1; done in cycle N+2 (LB 3, LH 4, LW 6).
- Next request is accepted no earlier than the cycle after done.
- All outputs are decoded from registered state/counter; stall_req alone has a combinational path from req_valid/req_rw.

## Configuration
- MEM_SEQ_ALIGN_CHECK_EN defined: half with addr[0]≠0 or word with addr[1:0]≠0 issues no controller access. It goes IDLE→DONE with done=1, misalign=1, rdata=0 in cycle 1.
- Undefined: misaligned accesses are performed byte-serially like aligned ones; misalign tied 0.

## Structure
- Shared defines package: RW_LOAD 2'b01, RW_STORE 2'b10, RW_NONE, SIZE_B/H/W encodings, state encodings, ZeroWord/ZeroByte.
- One sub-module: mem_load_ext (combinational size + signed extension of the assembled 32-bit result).

## Test plan
- LW addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 → addresses 0x100–0x103 on cycles 1–4 with rw=01, done cycle 6, rdata=0x44332211.
- LB signed addr 0x7, byte 0x80 → done cycle 3, rdata=0xFFFFFF80; same with req_signed=0 → 0x00000080.
- SH addr 0x20 wdata 0xDEADBEEF → cycle 1 addr 0x20 data 0xEF, cycle 2 addr 0x21 data 0xBE, rw=10, done cycle 3; stall_req 1 in cycles 0–2.
- LW addr 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted in cycle 2 of an SW → from cycle 3 rw_to_ctrl=00, stall_req=0, no done pulse.
- LH addr 0x3: with MEM_SEQ_ALIGN_CHECK_EN → no access, done+misalign cycle 1. Without the macro → addresses 0x3, 0x4, done cycle 4, misalign 0.

Source files
------------

// File: rtl/mem_byte_seq_pkg.sv
// mem_byte_seq_pkg: shared encodings for the byte-serial load/store sequencer.
package mem_byte_seq_pkg;
   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_LOAD  = 2'b01;
   localparam logic [1:0] RW_STORE = 2'b10;
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [31:0] ZeroWord = 32'h0;
   localparam logic [7:0] ZeroByte = 8'h0;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_DONE} state_t;
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      return size == SIZE_B ? 3'd1 : size == SIZE_H ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_byte_seq_load_ext.sv
// mem_load_ext: sign/zero extension of an assembled little-endian load result.
module mem_load_ext
   import mem_byte_seq_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] ext
);
   always_comb
      ext = size == SIZE_B ? {{24{sgn & raw[7]}}, raw[7:0]} :
            size == SIZE_H ? {{16{sgn & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: byte-serial load/store sequencer between MEM stage and memory controller.
// Optional MEM_SEQ_ALIGN_CHECK_EN: misaligned half/word faults instead of being performed.
module mem_byte_seq
   import mem_byte_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_rw,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic [1:0]  rw_to_ctrl,
   output logic [31:0] addr_to_ctrl,
   output logic [7:0]  data_to_ctrl,
   input  logic [7:0]  data_from_ctrl,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign
);
   state_t state, state_nxt;
   logic [2:0] k, k_nxt, n;
   logic [1:0] idx;
   logic [31:0] base, wdata, result, ext;
   logic [1:0] size;
   logic sgn, is_load, mis, accept, misal;

   assign accept = req_valid && (req_rw == RW_LOAD || req_rw == RW_STORE);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
   assign misal = (req_size == SIZE_H && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif
   assign n = size_bytes(size);
   // byte k-1 arrives the cycle after it was addressed
   assign idx = k[1:0] - 2'd1;

   mem_load_ext u_ext (.raw(result), .size(size), .sgn(sgn), .ext(ext));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         k <= 3'd0;
      end else begin
         state <= state_nxt;
         k <= k_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base <= ZeroWord;
         wdata <= ZeroWord;
         result <= ZeroWord;
         size <= SIZE_B;
         sgn <= 1'b0;
         is_load <= 1'b0;
         mis <= 1'b0;
      end else begin
         if (state == ST_IDLE && accept) begin
            base <= req_addr;
            wdata <= req_wdata;
            result <= ZeroWord;
            size <= req_size;
            sgn <= req_signed;
            is_load <= req_rw == RW_LOAD;
            mis <= misal;
         end
         if (state == ST_LOAD && k != 3'd0)
            result[{idx, 3'b000} +: 8] <= data_from_ctrl;
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt = k;
      rw_to_ctrl = RW_NONE;
      addr_to_ctrl = ZeroWord;
      data_to_ctrl = ZeroByte;
      done = 1'b0;
      rdata = ZeroWord;
      misalign = 1'b0;
      case (state)
         ST_IDLE: begin
            k_nxt = 3'd0;
            if (accept)
               state_nxt = misal ? ST_DONE : req_rw == RW_LOAD ? ST_LOAD : ST_STORE;
         end
         ST_STORE: begin
            rw_to_ctrl = RW_STORE;
            addr_to_ctrl = base + {29'd0, k};
            data_to_ctrl = wdata[{k[1:0], 3'b000} +: 8];
            k_nxt = k + 3'd1;
            state_nxt = k == n - 3'd1 ? ST_DONE : ST_STORE;
         end
         ST_LOAD: begin
            rw_to_ctrl = k < n ? RW_LOAD : RW_NONE;
            addr_to_ctrl = k < n ? base + {29'd0, k} : ZeroWord;
            k_nxt = k + 3'd1;
            state_nxt = k < n ? ST_LOAD : ST_DONE;
         end
         default: begin
            done = 1'b1;
            misalign = mis;
            rdata = is_load && !mis ? ext : ZeroWord;
            state_nxt = ST_IDLE;
         end
      endcase
      stall_req = state == ST_LOAD || state == ST_STORE || (state == ST_IDLE && accept);
   end
endmodule
